rv_dmem: RTL and testbench

//  Data-memory responder for the pipelined RV32I core's MEM-stage data port.

---
 rtl/rv_dmem_pkg.sv | 40 ++++
 rtl/rv_dmem_lsu_align.sv | 67 ++++++
 rtl/rv_dmem.sv | 189 ++++++++++++++++++
 tb/tb_rv_dmem.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_dmem_pkg.sv
// Shared configuration for the RV32I data-memory responder: data width,
// func3 size encodings, MMIO register offsets and fault codes.
package rv_dmem_pkg;

  localparam int XLEN = 32;

  // func3 encodings carried on the bytectrl port
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Offsets inside the MMIO window, relative to its base
  localparam logic [XLEN-1:0] MMIO_OFF_CYC_LO = 32'h0000_0000;
  localparam logic [XLEN-1:0] MMIO_OFF_CYC_HI = 32'h0000_0004;
  localparam logic [XLEN-1:0] MMIO_OFF_TOHOST = 32'h0000_0008;
  // The window covers 64 KiB; anything in it other than the three registers is unmapped
  localparam logic [XLEN-1:0] MMIO_SPAN       = 32'h0001_0000;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_MMIO     = 2'b11
  } fault_e;

  typedef struct packed {
    logic            valid;
    fault_e          ftype;
    logic [XLEN-1:0] addr;
  } fault_rec_t;

  // True when an MMIO window offset hits one of the implemented registers
  function automatic logic isMmioMapped(input logic [XLEN-1:0] off);
    return (off == MMIO_OFF_CYC_LO) || (off == MMIO_OFF_CYC_HI) ||
           (off == MMIO_OFF_TOHOST);
  endfunction

endpackage

// File: rtl/rv_dmem_lsu_align.sv
// Combinational load/store lane logic: byte enables and lane replication for
// stores, lane extraction with sign/zero extension for loads, misalign detect.
module rv_dmem_lsu_align
  import rv_dmem_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      bytectrl_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wlane_o,
  output logic [XLEN-1:0] rd_o,
  output logic            misalign_o,
  output logic            is_word_o
);

  logic [7:0]  rByte;
  logic [15:0] rHalf;

  assign rByte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rHalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Decode the access size into enables, replicated store lanes and load data;
  // unlisted func3 codes enable no lanes and read back zero
  always_comb begin
    be_o       = 4'b0000;
    wlane_o    = wd_i;
    rd_o       = '0;
    misalign_o = 1'b0;
    is_word_o  = 1'b0;
    case (bytectrl_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wlane_o = {4{wd_i[7:0]}};
        rd_o    = {{24{rByte[7]}}, rByte};
      end
      F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wlane_o = {4{wd_i[7:0]}};
        rd_o    = {24'h00_0000, rByte};
      end
      F3_H: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wlane_o    = {2{wd_i[15:0]}};
        rd_o       = {{16{rHalf[15]}}, rHalf};
        misalign_o = addr_lo_i[0];
      end
      F3_HU: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wlane_o    = {2{wd_i[15:0]}};
        rd_o       = {16'h0000, rHalf};
        misalign_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o       = 4'b1111;
        wlane_o    = wd_i;
        rd_o       = rword_i;
        misalign_o = (addr_lo_i != 2'b00);
        is_word_o  = 1'b1;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/rv_dmem.sv
// MEM-stage data memory for the pipelined RV32I core: word RAM with byte/half
// access, MMIO cycle counter with coherent high-half snapshot, tohost halt
// register, and a sticky record of the first illegal access.
// CYC_INIT is the counter's reset value; it is 0 in normal use.
module rv_dmem
  import rv_dmem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter logic [63:0]     CYC_INIT    = 64'd0
) (
  input  logic            i_dmem_clk,
  input  logic            i_dmem_rstn,
  input  logic [XLEN-1:0] i_dmem_a,
  input  logic [XLEN-1:0] i_dmem_wd,
  input  logic            i_dmem_we,
  input  logic            i_dmem_re,
  input  logic [2:0]      i_dmem_bytectrl,
  output logic [XLEN-1:0] o_dmem_rd,
  output logic            o_dmem_halt,
  output logic [XLEN-1:0] o_dmem_tohost,
  output logic            o_dmem_fault,
  output logic [XLEN-1:0] o_dmem_fault_addr,
  output logic [1:0]      o_dmem_fault_type
);

  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(4 * DEPTH_WORDS);

  logic [XLEN-1:0] ramMem [DEPTH_WORDS];
  logic [AW-1:0]   wordIdx;
  logic [XLEN-1:0] ramWord;

  logic [3:0]      byteEn;
  logic [XLEN-1:0] wLane;
  logic [XLEN-1:0] alignRd;
  logic            misalign;
  logic            isWord;

  logic [XLEN-1:0] mmioOff;
  logic            inRam;
  logic            inMmio;
  logic            isCycLo;
  logic            isCycHi;
  logic            isTohost;
  logic            accessQual;
  fault_e          accessFault;
  logic            illegal;
  logic            ramWe;
  logic            tohostWe;
  logic            cycLoRead;
  logic [XLEN-1:0] mmioWord;
  logic [XLEN-1:0] rdData;

  logic [63:0]     cyc_q,    cyc_d;
  logic [XLEN-1:0] shadow_q, shadow_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic            halt_q,   halt_d;
  fault_rec_t      fault_q,  fault_d;

  assign wordIdx = i_dmem_a[AW+1:2];
  assign ramWord = ramMem[wordIdx];

  rv_dmem_lsu_align u_align (
    .addr_lo_i  (i_dmem_a[1:0]),
    .bytectrl_i (i_dmem_bytectrl),
    .wd_i       (i_dmem_wd),
    .rword_i    (ramWord),
    .be_o       (byteEn),
    .wlane_o    (wLane),
    .rd_o       (alignRd),
    .misalign_o (misalign),
    .is_word_o  (isWord)
  );

  assign mmioOff    = i_dmem_a - MMIO_BASE;
  assign inRam      = (i_dmem_a < RAM_BYTES);
  assign inMmio     = (mmioOff < MMIO_SPAN);
  assign isCycLo    = inMmio && (mmioOff == MMIO_OFF_CYC_LO);
  assign isCycHi    = inMmio && (mmioOff == MMIO_OFF_CYC_HI);
  assign isTohost   = inMmio && (mmioOff == MMIO_OFF_TOHOST);
  assign accessQual = i_dmem_re | i_dmem_we;

  // Classify the current access; only qualified accesses can fault, and a
  // misaligned address outranks every other reason
  always_comb begin
    accessFault = FAULT_NONE;
    if (accessQual) begin
      if (misalign) begin
        accessFault = FAULT_MISALIGN;
      end else if (inRam) begin
        accessFault = FAULT_NONE;
      end else if (inMmio) begin
        if (!isWord || !isMmioMapped(mmioOff) || (i_dmem_we && !isTohost)) begin
          accessFault = FAULT_MMIO;
        end
      end else begin
        accessFault = FAULT_RANGE;
      end
    end
  end

  assign illegal   = (accessFault != FAULT_NONE);
  // A store racing an asserted reset must not reach the (unreset) RAM
  assign ramWe     = i_dmem_we && !illegal && inRam && i_dmem_rstn;
  assign tohostWe  = i_dmem_we && !illegal && isTohost;
  // The concurrent-store case still snapshots the high half on a CYC_LO read
  assign cycLoRead = i_dmem_re && isCycLo && isWord && !misalign;

  // Zero-latency read mux: RAM lanes or MMIO register, forced to 0 when illegal
  always_comb begin
    mmioWord = '0;
    if (isCycLo) begin
      mmioWord = cyc_q[31:0];
    end else if (isCycHi) begin
      mmioWord = shadow_q;
    end else if (isTohost) begin
      mmioWord = tohost_q;
    end
    rdData = '0;
    if (!illegal) begin
      if (inRam) begin
        rdData = alignRd;
      end else if (inMmio) begin
        rdData = mmioWord;
      end
    end
  end

  assign o_dmem_rd = rdData;

  // Next-state for counter, shadow, tohost, halt and the first-fault record
  always_comb begin
    cyc_d    = cyc_q + 64'd1;
    shadow_d = shadow_q;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    fault_d  = fault_q;
    if (cycLoRead) begin
      shadow_d = cyc_q[63:32];
    end
    if (tohostWe) begin
      tohost_d = i_dmem_wd;
      if (i_dmem_wd != '0) begin
        halt_d = 1'b1;
      end
    end
    if (illegal && !fault_q.valid) begin
      fault_d.valid = 1'b1;
      fault_d.ftype = accessFault;
      fault_d.addr  = i_dmem_a;
    end
  end

  // Control registers clear asynchronously on reset
  always_ff @(posedge i_dmem_clk or negedge i_dmem_rstn) begin
    if (!i_dmem_rstn) begin
      cyc_q    <= CYC_INIT;
      shadow_q <= '0;
      tohost_q <= '0;
      halt_q   <= 1'b0;
      fault_q  <= '0;
    end else begin
      cyc_q    <= cyc_d;
      shadow_q <= shadow_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
      fault_q  <= fault_d;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset
  always_ff @(posedge i_dmem_clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          ramMem[wordIdx][i*8 +: 8] <= wLane[i*8 +: 8];
        end
      end
    end
  end

  assign o_dmem_halt       = halt_q;
  assign o_dmem_tohost     = tohost_q;
  assign o_dmem_fault      = fault_q.valid;
  assign o_dmem_fault_addr = fault_q.addr;
  assign o_dmem_fault_type = fault_q.ftype;

endmodule

// File: tb/tb_rv_dmem.sv
// Self-checking bench for rv_dmem: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-level reference model.
module tb_rv_dmem;
  import rv_dmem_pkg::*;

  localparam logic [31:0] BASE      = 32'hFFFF_0000;
  localparam logic [63:0] CYC2_INIT = 64'h0000_0000_FFFF_FFFA;
  localparam int          NVEC      = 14;
  localparam int          NRAND     = 300;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        rstn2 = 1'b1;
  logic [31:0] a     = '0;
  logic [31:0] wd    = '0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [2:0]  bc    = F3_W;

  logic [31:0] rd, tohost, faultAddr;
  logic        halt, fault;
  logic [1:0]  faultType;
  logic [31:0] rd2, tohost2, faultAddr2;
  logic        halt2, fault2;
  logic [1:0]  faultType2;

  int checks   = 0;
  int failures = 0;

  rv_dmem #(.DEPTH_WORDS(1024), .MMIO_BASE(BASE), .CYC_INIT(64'd0)) dut (
    .i_dmem_clk(clk), .i_dmem_rstn(rstn), .i_dmem_a(a), .i_dmem_wd(wd),
    .i_dmem_we(we), .i_dmem_re(re), .i_dmem_bytectrl(bc),
    .o_dmem_rd(rd), .o_dmem_halt(halt), .o_dmem_tohost(tohost),
    .o_dmem_fault(fault), .o_dmem_fault_addr(faultAddr), .o_dmem_fault_type(faultType)
  );

  // Second instance preset near a 2^32 carry to exercise the hi snapshot
  rv_dmem #(.DEPTH_WORDS(1024), .MMIO_BASE(BASE), .CYC_INIT(CYC2_INIT)) dutCarry (
    .i_dmem_clk(clk), .i_dmem_rstn(rstn2), .i_dmem_a(a), .i_dmem_wd(wd),
    .i_dmem_we(we), .i_dmem_re(re), .i_dmem_bytectrl(bc),
    .o_dmem_rd(rd2), .o_dmem_halt(halt2), .o_dmem_tohost(tohost2),
    .o_dmem_fault(fault2), .o_dmem_fault_addr(faultAddr2), .o_dmem_fault_type(faultType2)
  );

  always #5 clk = ~clk;

  // Reference cycle count: cycles elapsed since reset release
  logic [63:0] cyc1M;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc1M <= 64'd0;
    else       cyc1M <= cyc1M + 64'd1;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wEn;
    logic        rEn;
    logic [2:0]  ctl;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference model state for the random phase
  logic [7:0]  memM [int];
  logic        faultM, haltM;
  logic [1:0]  ftypeM;
  logic [31:0] faddrM, tohostM, shadowM;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic wEn, input logic rEn, input logic [2:0] ctl);
    a  = addr;
    wd = data;
    we = wEn;
    re = rEn;
    bc = ctl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, F3_W);
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] ctl);
    logic [7:0]  b0;
    logic [15:0] h;
    b0 = memM[int'(addr)];
    h  = {memM[int'(addr) + 1], memM[int'(addr)]};
    case (ctl)
      F3_B:    return {{24{b0[7]}}, b0};
      F3_BU:   return {24'h0, b0};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return {memM[int'(addr) + 3], memM[int'(addr) + 2], h};
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h10, 32'h8899AABB, 1'b1, 1'b0, F3_W,  1'b0, 32'h0};
    vecs[1]  = '{32'h14, 32'h11223344, 1'b1, 1'b0, F3_W,  1'b0, 32'h0};
    vecs[2]  = '{32'h00, 32'h01020304, 1'b1, 1'b0, F3_W,  1'b0, 32'h0};
    vecs[3]  = '{32'h11, 32'h0,        1'b0, 1'b1, F3_B,  1'b1, 32'hFFFFFFAA};
    vecs[4]  = '{32'h11, 32'h0,        1'b0, 1'b1, F3_BU, 1'b1, 32'h000000AA};
    vecs[5]  = '{32'h12, 32'h0,        1'b0, 1'b1, F3_H,  1'b1, 32'hFFFF8899};
    vecs[6]  = '{32'h12, 32'h0,        1'b0, 1'b1, F3_HU, 1'b1, 32'h00008899};
    vecs[7]  = '{32'h10, 32'h0,        1'b0, 1'b1, F3_W,  1'b1, 32'h8899AABB};
    vecs[8]  = '{32'h13, 32'h1234565A, 1'b1, 1'b0, F3_B,  1'b0, 32'h0};
    vecs[9]  = '{32'h10, 32'h0,        1'b0, 1'b1, F3_W,  1'b1, 32'h5A99AABB};
    vecs[10] = '{32'h13, 32'h0,        1'b0, 1'b1, F3_BU, 1'b1, 32'h0000005A};
    vecs[11] = '{32'h16, 32'hCAFEBEEF, 1'b1, 1'b0, F3_H,  1'b0, 32'h0};
    vecs[12] = '{32'h14, 32'h0,        1'b0, 1'b1, F3_W,  1'b1, 32'hBEEF3344};
    vecs[13] = '{32'h17, 32'h0,        1'b0, 1'b1, F3_B,  1'b1, 32'hFFFFFFBE};

    // Reset state
    idle();
    rstn = 1'b0;
    rstn2 = 1'b0;
    #1;
    checkOutput("reset halt", {63'd0, halt}, 64'd0);
    checkOutput("reset tohost", {32'd0, tohost}, 64'd0);
    checkOutput("reset fault", {63'd0, fault}, 64'd0);
    checkOutput("reset fault_addr", {32'd0, faultAddr}, 64'd0);
    checkOutput("reset fault_type", {62'd0, faultType}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    rstn2 = 1'b1;
    idle();
    @(negedge clk);

    // Directed load/store vectors
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].wEn, vecs[i].rEn, vecs[i].ctl);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d rd", i), {32'd0, rd}, {32'd0, vecs[i].exp});
      @(negedge clk);
    end
    idle();
    checkOutput("no fault after vectors", {63'd0, fault}, 64'd0);

    // Misaligned word load, then an out-of-range store that must not overwrite the record
    applyStimulus(32'h12, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("misaligned rd", {32'd0, rd}, 64'd0);
    @(negedge clk);
    checkOutput("misaligned fault", {63'd0, fault}, 64'd1);
    checkOutput("misaligned type", {62'd0, faultType}, 64'd1);
    checkOutput("misaligned addr", {32'd0, faultAddr}, 64'h12);
    applyStimulus(32'h0010_0000, 32'hDEADBEEF, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    checkOutput("sticky type", {62'd0, faultType}, 64'd1);
    checkOutput("sticky addr", {32'd0, faultAddr}, 64'h12);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("ram after oor store", {32'd0, rd}, 64'h01020304);
    @(negedge clk);

    // TOHOST and halt
    applyStimulus(BASE + 32'h8, 32'h0, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    checkOutput("halt after zero", {63'd0, halt}, 64'd0);
    applyStimulus(BASE + 32'h8, 32'h1, 1'b1, 1'b0, F3_W);
    checkOutput("halt before edge", {63'd0, halt}, 64'd0);
    @(negedge clk);
    checkOutput("halt set", {63'd0, halt}, 64'd1);
    checkOutput("tohost one", {32'd0, tohost}, 64'd1);
    applyStimulus(BASE + 32'h8, 32'h77, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    applyStimulus(BASE + 32'h8, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("tohost readback", {32'd0, rd}, 64'h77);
    @(negedge clk);
    applyStimulus(BASE + 32'h8, 32'h0, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    checkOutput("halt sticky", {63'd0, halt}, 64'd1);
    checkOutput("tohost zero", {32'd0, tohost}, 64'd0);
    applyStimulus(BASE + 32'h8, 32'h3, 1'b1, 1'b0, F3_H);
    @(negedge clk);
    checkOutput("sh tohost keeps record", {62'd0, faultType}, 64'd1);
    checkOutput("sh tohost suppressed", {32'd0, tohost}, 64'd0);

    // Counter snapshot across a 2^32 carry on the preset instance
    idle();
    rstn2 = 1'b0;
    #1;
    rstn2 = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(BASE, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("cyc lo before carry", {32'd0, rd2}, 64'hFFFFFFFE);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    applyStimulus(BASE + 32'h4, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("cyc hi shadow", {32'd0, rd2}, 64'd0);
    @(negedge clk);
    applyStimulus(BASE, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("cyc lo after carry", {32'd0, rd2}, 64'd2);
    @(negedge clk);
    applyStimulus(BASE + 32'h4, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("cyc hi after carry", {32'd0, rd2}, 64'd1);
    @(negedge clk);

    // Reset during a store
    applyStimulus(32'h20, 32'h11111111, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    applyStimulus(32'h20, 32'h22222222, 1'b1, 1'b0, F3_W);
    rstn = 1'b0;
    #1;
    checkOutput("async halt clear", {63'd0, halt}, 64'd0);
    checkOutput("async fault clear", {63'd0, fault}, 64'd0);
    checkOutput("async fault_addr clear", {32'd0, faultAddr}, 64'd0);
    checkOutput("async fault_type clear", {62'd0, faultType}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("store dropped in reset", {32'd0, rd}, 64'h11111111);
    @(negedge clk);
    applyStimulus(BASE, 32'h0, 1'b0, 1'b1, F3_W);
    checkOutput("counter restarts", {32'd0, rd}, 64'd1);
    @(negedge clk);
    applyStimulus(BASE + 32'h8, 32'h5, 1'b1, 1'b0, F3_H);
    @(negedge clk);
    checkOutput("mmio size fault", {63'd0, fault}, 64'd1);
    checkOutput("mmio size type", {62'd0, faultType}, 64'd3);
    checkOutput("mmio size addr", {32'd0, faultAddr}, {32'd0, BASE + 32'h8});
    checkOutput("mmio size no halt", {63'd0, halt}, 64'd0);

    // Randomized traffic against the reference model, starting from a fresh reset
    idle();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    faultM = 1'b0; haltM = 1'b0; ftypeM = 2'b00;
    faddrM = '0; tohostM = '0; shadowM = '0;
    @(negedge clk);
    for (int w = 0; w < 17; w++) begin
      logic [31:0] ia, iv;
      ia = (w == 16) ? 32'd4092 : 32'(w * 4);
      iv = $urandom;
      applyStimulus(ia, iv, 1'b1, 1'b0, F3_W);
      for (int k = 0; k < 4; k++) memM[int'(ia) + k] = iv[k*8 +: 8];
      @(negedge clk);
    end

    for (int n = 0; n < NRAND; n++) begin
      logic [31:0] ra, rw, off, expRd;
      logic        rwe, rre, isH, isW, misal, inRam, inMmio, mapped;
      logic [1:0]  ft;
      logic [2:0]  rbc;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 32'($urandom_range(0, 63));
      else if (sel == 7) ra = 32'(4092 + $urandom_range(0, 7));
      else if (sel == 8) ra = BASE + 32'($urandom_range(0, 15));
      else               ra = 32'h0001_0000 + 32'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0:       rbc = F3_B;
        1:       rbc = F3_H;
        2:       rbc = F3_W;
        3:       rbc = F3_BU;
        default: rbc = F3_HU;
      endcase
      rwe = 1'($urandom_range(0, 1));
      rre = 1'($urandom_range(0, 1));
      rw  = $urandom;

      isH    = (rbc == F3_H) || (rbc == F3_HU);
      isW    = (rbc == F3_W);
      misal  = (isH && ra[0]) || (isW && (ra % 4 != 0));
      inRam  = (ra < 32'd4096);
      inMmio = (ra >= BASE);
      off    = ra - BASE;
      mapped = (off == 0) || (off == 4) || (off == 8);
      ft = 2'b00;
      if (rwe || rre) begin
        if (misal)       ft = 2'b01;
        else if (inRam)  ft = 2'b00;
        else if (inMmio) ft = (!isW || !mapped || (rwe && off != 8)) ? 2'b11 : 2'b00;
        else             ft = 2'b10;
      end

      expRd = 32'h0;
      if (ft == 2'b00) begin
        if (inRam)                 expRd = modelLoad(ra, rbc);
        else if (inMmio && off == 0) expRd = cyc1M[31:0];
        else if (inMmio && off == 4) expRd = shadowM;
        else if (inMmio && off == 8) expRd = tohostM;
      end

      applyStimulus(ra, rw, rwe, rre, rbc);
      if (rre) checkOutput($sformatf("rand%0d rd a=%h f3=%0d we=%0b", n, ra, rbc, rwe), {32'd0, rd}, {32'd0, expRd});

      if (rre && inMmio && off == 0 && isW) shadowM = cyc1M[63:32];
      if (rwe && ft == 2'b00) begin
        if (inRam) begin
          memM[int'(ra)] = rw[7:0];
          if (isH || isW) memM[int'(ra) + 1] = rw[15:8];
          if (isW) begin
            memM[int'(ra) + 2] = rw[23:16];
            memM[int'(ra) + 3] = rw[31:24];
          end
        end else if (inMmio && off == 8) begin
          tohostM = rw;
          if (rw != 0) haltM = 1'b1;
        end
      end
      if (ft != 2'b00 && !faultM) begin
        faultM = 1'b1;
        ftypeM = ft;
        faddrM = ra;
      end

      @(negedge clk);
      checkOutput($sformatf("rand%0d fault", n), {63'd0, fault}, {63'd0, faultM});
      checkOutput($sformatf("rand%0d fault_type", n), {62'd0, faultType}, {62'd0, ftypeM});
      checkOutput($sformatf("rand%0d fault_addr", n), {32'd0, faultAddr}, {32'd0, faddrM});
      checkOutput($sformatf("rand%0d halt", n), {63'd0, halt}, {63'd0, haltM});
      checkOutput($sformatf("rand%0d tohost", n), {32'd0, tohost}, {32'd0, tohostM});
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
